// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button input front end.
// Imported by btn_debounce_ch, btn_event_rx and the game FSM.
package btn_pkg;

    localparam int NUM_BTN_DEF    = 8;
    localparam int DEBOUNCE_DEF   = 1000;
    localparam int FIFO_DEPTH_DEF = 4;

    // Widths never collapse to zero, even for tiny parameter values.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BTN_IDX_W = idx_w(NUM_BTN_DEF);
    localparam int CNT_W     = cnt_w(DEBOUNCE_DEF);

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, counter debounce, registered rise pulse.
// Ports: clk, rst_n, ena, raw (async in), level (debounced), rise (1-cycle).
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = sync2 ^ level;
    assign accept = differ && (cnt == CNT_MAX);

    // Synchroniser runs regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else if (ena) begin
            rise <= accept & sync2;
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                level <= sync2;
            end
        end else begin
            rise <= 1'b0;
        end
    end

endmodule

// File: rtl/btn_event_rx.sv
// Button bank front end: per-button debounce plus a press-event FIFO.
// Ports: clk, rst_n, ena, btn_raw -> btn_level, btn_rise; evt_* FIFO view.
module btn_event_rx
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [NUM_BTN-1:0]            btn_raw,
    output logic [NUM_BTN-1:0]            btn_level,
    output logic [NUM_BTN-1:0]            btn_rise,
    output logic                          evt_valid,
    output logic [idx_w(NUM_BTN)-1:0]     evt_btn,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          evt_overflow,
    input  logic                          clr_overflow
);

    localparam int IW = idx_w(NUM_BTN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] push_oh;
    logic [NUM_BTN-1:0] ovf_hit;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               has_room;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .rise (btn_rise[g])
        );
    end

    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign has_room  = (evt_count < OW'(FIFO_DEPTH)) || pop;
    assign push      = (|pending) && has_room;
    assign evt_btn   = evt_valid ? mem[rd_ptr] : '0;

    // Lowest set pending bit wins: scan downwards, last hit sticks.
    always_comb begin
        push_idx = '0;
        push_oh  = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push_idx = IW'(i);
            end
        end
        if (push) begin
            push_oh[push_idx] = 1'b1;
        end
    end

    assign ovf_hit = btn_rise & pending & ~push_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pending <= (pending & ~push_oh) | btn_rise;
            if (|ovf_hit) begin
                evt_overflow <= 1'b1;
            end else if (clr_overflow) begin
                evt_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                evt_count <= evt_count + 1'b1;
            end else if (pop && !push) begin
                evt_count <= evt_count - 1'b1;
            end
        end
    end

endmodule

// File: doc/btn_event_rx.md
Name: btn_event_rx

Overview:
- Input-side front end for the whack-a-mole core. The core drives the display; this block receives the raw button bank feeding it.
- Per button: 2-FF synchronisation, counter-based debounce, one-cycle press pulse.
- Serialises press events into a small FIFO, read through a valid/ready handshake.
- Sits between the pads and the game FSM. It replaces direct use of raw btn and provides both level and event views.

Parameters:
- NUM_BTN, 8, number of buttons; event index width is clog2(NUM_BTN).
- DEBOUNCE_CYCLES, 1000, consecutive cycles a new synced level must hold before acceptance; minimum 2.
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  debounce/event enable.
- btn_raw  in  NUM_BTN  asynchronous button inputs, active-high.
- btn_level  out  NUM_BTN  debounced level.
- btn_rise  out  NUM_BTN  one-cycle pulse on a debounced 0->1 transition.
- evt_valid  out  1  FIFO non-empty.
- evt_btn  out  clog2(NUM_BTN)  button index at FIFO head (show-ahead).
- evt_ready  in  1  consumer pop; a pop occurs when evt_valid && evt_ready.
- evt_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- evt_overflow  out  1  sticky: a press event was lost.
- clr_overflow  in  1  synchronous clear of evt_overflow.

Behaviour:
- Reset (async, rst_n=0):
  - sync flops, btn_level, btn_rise, debounce counters, pending mask, FIFO pointers all 0.
  - evt_valid=0, evt_btn=0, evt_count=0, evt_overflow=0.
  - Reset mid-operation discards all queued and pending events.
- Synchroniser: 2 flops per button. sync2 lags btn_raw by 2 edges.
- Debounce, per button:
  - If sync2==btn_level, counter<=0.
  - Else counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and sync2 still differs: btn_level<=sync2 and counter<=0.
  - A raw change held steadily appears on btn_level DEBOUNCE_CYCLES+2 edges later.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- btn_rise:
  - Registered; asserts on the same edge btn_level goes 0->1, lasts exactly 1 cycle.
  - No pulse on release.
- ena=0:
  - Sync flops keep running. Debounce counters and btn_level hold; btn_rise is 0.
  - Pending drain and FIFO pops continue.
  - On ena re-assertion, debounce resumes from the held counter values.
- Pending mask (NUM_BTN bits), evaluated every cycle:
  - A btn_rise bit sets the corresponding pending bit on the next edge.
  - Each cycle the lowest-index set pending bit is pushed into the FIFO and cleared, if push is allowed.
  - Push is allowed when evt_count<FIFO_DEPTH, or a pop occurs in the same cycle (simultaneous push+pop when full is legal).
  - At most one push per cycle. Simultaneous presses drain in ascending index order, one per cycle.
  - Latency: btn_rise in cycle N gives evt_valid in cycle N+2 when the FIFO is empty and no lower pending bit exists.
- Overflow:
  - If btn_rise[i] fires while pending[i] is still set and not being pushed that cycle, the new event is dropped and evt_overflow<=1.
  - Pending bits are never lost because the FIFO is full; they wait.
  - clr_overflow clears the flag unless a new overflow occurs on the same edge; set wins.
- FIFO:
  - Circular buffer with read/write pointers; evt_count updates the same edge as push/pop.
  - evt_btn shows the head entry combinationally from the storage array; it is 0 when empty (evt_valid=0).
  - A pop when empty is ignored.
  - evt_btn must remain stable while evt_valid && !evt_ready.

Decomposition:
- Shared package btn_pkg:
  - localparams BTN_IDX_W and CNT_W (clog2 helpers).
  - Default DEBOUNCE_CYCLES.
  - btn_idx_t typedef, shared with the game FSM.
- One natural sub-module: btn_debounce_ch (sync + counter + level + rise for one button), instantiated NUM_BTN times via generate.
- Pending arbitration (priority encoder) and the FIFO stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset/idle: rst_n low, btn_raw=8'hFF -> all outputs 0. After release, btn_level=8'hFF exactly 6 edges later, btn_rise=8'hFF for 1 cycle.
- Glitch reject: btn_raw[3] high for 3 cycles, then low -> btn_level[3], btn_rise and evt_valid stay 0 throughout.
- Single press: btn_raw[5] 0->1 held, evt_ready=0 -> btn_rise[5] at edge 6, evt_valid=1 with evt_btn=5 at edge 8, evt_count=1. One-cycle evt_ready -> evt_valid=0 next cycle.
- Simultaneous press: btn_raw 8'h00->8'h91, evt_ready=1 -> evt_btn sequence 0,4,7 on consecutive cycles, no overflow.
- Full/backpressure: evt_ready=0, presses on buttons 0..5 -> evt_count saturates at 4, pending holds 4 and 5. Hold press/release on button 4 again -> evt_overflow=1. Drain: indices 0,1,2,3,4,5 in order. clr_overflow -> evt_overflow=0.
- Reset mid-operation: FIFO holds 3 events, rst_n pulse -> evt_valid=0, evt_count=0, no stale event after reset release.
